b_muxn_scan: RTL and testbench

//   Parametrised registered N:1 multiplexer: successor to the 2:1 behavioural mux.
//   - Selects one WIDTH-bit channel from NUM_IN packed inputs.
//   - Manual mode: select loaded on a strobe. Scan mode: internal dwell counter auto-steps the select.
//   - Sits between sampled input banks and a single downstream consumer (display/serialiser).

---
 rtl/b_mux_pkg.sv | 18 +
 rtl/b_dwell_cnt.sv | 31 +++
 rtl/b_muxn_scan.sv | 159 +++++++++++++++
 tb/tb_b_muxn_scan.sv | 498 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/b_mux_pkg.sv
// b_mux_pkg: FSM encoding and width helpers for the scanning N:1 mux.
// Shared by b_dwell_cnt and b_muxn_scan.
package b_mux_pkg;

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_SCAN   = 1'b1
  } state_e;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int d);
    return $clog2(d + 1);
  endfunction

endpackage

// File: rtl/b_dwell_cnt.sv
// b_dwell_cnt: free-running 0..DWELL-1 counter with
// synchronous clear and terminal-count flag.
module b_dwell_cnt
  import b_mux_pkg::*;
#(
  parameter int DWELL = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  output logic o_tc
);

  localparam int CW = cnt_w(DWELL);
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] r_cnt;

  assign o_tc = (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || o_tc) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/b_muxn_scan.sv
// b_muxn_scan: registered N:1 mux with manual select or dwell scan.
// Optional per-channel enable mask via B_MUX_CH_MASK_EN.
module b_muxn_scan
  import b_mux_pkg::*;
#(
  parameter  int WIDTH  = 1,
  parameter  int NUM_IN = 2,
  parameter  int DWELL  = 100,
  localparam int SEL_W  = sel_w(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] i,
  input  logic                    scan,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    load,
`ifdef B_MUX_CH_MASK_EN
  input  logic [NUM_IN-1:0]       ch_mask,
`endif
  output logic [WIDTH-1:0]        y,
  output logic [SEL_W-1:0]        cur_sel,
  output logic                    y_vld,
  output logic                    sel_err
);

  state_e r_state;
  state_e w_state_nxt;

  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] w_sel_nxt;
  logic [SEL_W-1:0] w_nxt_hi;
  logic [SEL_W-1:0] w_nxt_lo;
  logic [SEL_W-1:0] w_adv_sel;
  logic             w_hi_ok;
  logic             w_lo_ok;
  logic             w_adv_ok;

  logic [NUM_IN-1:0] w_mask;
  logic              w_sel_ok;
  logic              w_run;
  logic              w_tc;

  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] w_y_nxt;
  logic             r_vld;
  logic             w_vld_nxt;
  logic             r_err;
  logic             w_err_nxt;

`ifdef B_MUX_CH_MASK_EN
  assign w_mask = ch_mask;
`else
  assign w_mask = '1;
`endif

  // Counter only runs while scanning and scan is still requested;
  // any other cycle holds it at zero.
  assign w_run = (r_state == ST_SCAN) && scan;

  b_dwell_cnt #(
    .DWELL (DWELL)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (!w_run),
    .o_tc  (w_tc)
  );

  // Next enabled channel after r_sel: lowest enabled above it,
  // otherwise wrap to the lowest enabled at or below it.
  always_comb begin
    w_nxt_hi = r_sel;
    w_hi_ok  = 1'b0;
    w_nxt_lo = r_sel;
    w_lo_ok  = 1'b0;
    for (int j = NUM_IN - 1; j >= 0; j--) begin
      if (w_mask[j] && (SEL_W'(j) > r_sel)) begin
        w_nxt_hi = SEL_W'(j);
        w_hi_ok  = 1'b1;
      end
      if (w_mask[j] && (SEL_W'(j) <= r_sel)) begin
        w_nxt_lo = SEL_W'(j);
        w_lo_ok  = 1'b1;
      end
    end
  end

  assign w_adv_sel = w_hi_ok ? w_nxt_hi : w_nxt_lo;
  assign w_adv_ok  = w_hi_ok | w_lo_ok;

  // A request is valid only if it names an existing, enabled channel.
  always_comb begin
    w_sel_ok = 1'b0;
    for (int j = 0; j < NUM_IN; j++) begin
      if (sel == SEL_W'(j)) begin
        w_sel_ok = w_mask[j];
      end
    end
  end

  always_comb begin
    w_state_nxt = scan ? ST_SCAN : ST_MANUAL;
    w_sel_nxt   = r_sel;
    w_vld_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    unique case (r_state)
      ST_MANUAL: begin
        if (load) begin
          if (w_sel_ok) begin
            w_sel_nxt = sel;
            w_vld_nxt = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      ST_SCAN: begin
        if (w_run && w_tc && w_adv_ok) begin
          w_sel_nxt = w_adv_sel;
          w_vld_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_MANUAL;
      end
    endcase
  end

  always_comb begin
    w_y_nxt = '0;
    for (int j = 0; j < NUM_IN; j++) begin
      if (w_sel_nxt == SEL_W'(j)) begin
        w_y_nxt = i[j*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_MANUAL;
      r_sel   <= '0;
      r_y     <= '0;
      r_vld   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_y     <= w_y_nxt;
      r_vld   <= w_vld_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign y       = r_y;
  assign cur_sel = r_sel;
  assign y_vld   = r_vld;
  assign sel_err = r_err;

endmodule

// File: tb/tb_b_muxn_scan.sv
// tb_b_muxn_scan: scoreboard bench for b_muxn_scan.
// u0: 3x4-bit, DWELL=3; u1: single 2-bit channel, DWELL=1.
module tb_b_muxn_scan;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [11:0] i0;
  logic        scan0;
  logic        load0;
  logic [1:0]  sel0;
  logic [3:0]  y0;
  logic [1:0]  cs0;
  logic        vld0;
  logic        err0;
`ifdef B_MUX_CH_MASK_EN
  logic [2:0]  ch_mask0;
`endif

  logic [1:0] i1;
  logic       scan1;
  logic       load1;
  logic [0:0] sel1;
  logic [1:0] y1;
  logic [0:0] cs1;
  logic       vld1;
  logic       err1;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [3:0] y;
    logic [1:0] cs;
    logic       vld;
    logic       err;
  } e0_t;

  typedef struct packed {
    logic [1:0] y;
    logic       cs;
    logic       vld;
    logic       err;
  } e1_t;

  e0_t q0[$];
  e1_t q1[$];

  bit m_st;
  int m_cnt;
  int m_sel;

  always #5 clk = ~clk;

  b_muxn_scan #(
    .WIDTH  (4),
    .NUM_IN (3),
    .DWELL  (3)
  ) u0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i       (i0),
    .scan    (scan0),
    .sel     (sel0),
    .load    (load0),
`ifdef B_MUX_CH_MASK_EN
    .ch_mask (ch_mask0),
`endif
    .y       (y0),
    .cur_sel (cs0),
    .y_vld   (vld0),
    .sel_err (err0)
  );

  b_muxn_scan #(
    .WIDTH  (2),
    .NUM_IN (1),
    .DWELL  (1)
  ) u1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i       (i1),
    .scan    (scan1),
    .sel     (sel1),
    .load    (load1),
`ifdef B_MUX_CH_MASK_EN
    .ch_mask (1'b1),
`endif
    .y       (y1),
    .cur_sel (cs1),
    .y_vld   (vld1),
    .sel_err (err1)
  );

  function automatic bit en0(input int c);
`ifdef B_MUX_CH_MASK_EN
    return ch_mask0[c];
`else
    return c >= 0;
`endif
  endfunction

  function automatic logic [3:0] chan0(input int s);
    return i0[s*4 +: 4];
  endfunction

  // Reference model for u0: predicts the outputs after the next edge.
  task automatic step0();
    e0_t e;
    int  n;
    e.vld = 1'b0;
    e.err = 1'b0;
    if (m_st && scan0) begin
      if (m_cnt == 2) begin
        m_cnt = 0;
        n = -1;
        for (int k = 1; k <= 3; k++) begin
          if (n < 0 && en0((m_sel + k) % 3)) n = (m_sel + k) % 3;
        end
        if (n >= 0) begin
          m_sel = n;
          e.vld = 1'b1;
        end
      end else begin
        m_cnt++;
      end
    end else begin
      m_cnt = 0;
    end
    if (!m_st && load0) begin
      if (sel0 < 3 && en0(int'(sel0))) begin
        m_sel = int'(sel0);
        e.vld = 1'b1;
      end else begin
        e.err = 1'b1;
      end
    end
    m_st = scan0;
    e.y  = chan0(m_sel);
    e.cs = 2'(m_sel);
    q0.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic step1(input e1_t e);
    q1.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    total++;
    if ({y0, cs0, vld0, err0} !== 8'h00 || {y1, cs1, vld1, err1} !== 5'h00) begin
      bad++;
      $display("FAIL reset_por: u0=%h u1=%h want 0", {y0, cs0, vld0, err0}, {y1, cs1, vld1, err1});
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_manual();
    logic [2:0] rows [6];
    e0_t e;
    rows = '{3'b110, 3'b000, 3'b100, 3'b100, 3'b000, 3'b101};
    i0 = 12'hCBA;
    scan0 = 1'b0;
    for (int r = 0; r < 6; r++) begin
      load0 = rows[r][2];
      sel0  = rows[r][1:0];
      if (r == 4) i0 = 12'hC57;
      step0();
      e = q0.pop_front();
      total++;
      if ({y0, cs0, vld0, err0} !== e) begin
        bad++;
        $display("FAIL manual[%0d]: got y=%h sel=%0d vld=%b err=%b want y=%h sel=%0d vld=%b err=%b",
                 r, y0, cs0, vld0, err0, e.y, e.cs, e.vld, e.err);
      end
      if (r == 0) begin
        total++;
        if (y0 !== 4'hC || cs0 !== 2'd2 || vld0 !== 1'b1) begin
          bad++;
          $display("FAIL manual_sel2: got y=%h sel=%0d vld=%b want y=c sel=2 vld=1", y0, cs0, vld0);
        end
      end
    end
    load0 = 1'b0;
  endtask

  task automatic test_bad_sel();
    logic [2:0] rows [4];
    e0_t e;
    rows = '{3'b111, 3'b000, 3'b111, 3'b011};
    for (int r = 0; r < 4; r++) begin
      load0 = rows[r][2];
      sel0  = rows[r][1:0];
      step0();
      e = q0.pop_front();
      total++;
      if ({y0, cs0, vld0, err0} !== e) begin
        bad++;
        $display("FAIL bad_sel[%0d]: got y=%h sel=%0d vld=%b err=%b want y=%h sel=%0d vld=%b err=%b",
                 r, y0, cs0, vld0, err0, e.y, e.cs, e.vld, e.err);
      end
      if (r == 0) begin
        total++;
        if (err0 !== 1'b1 || cs0 !== 2'd1 || y0 !== 4'h5) begin
          bad++;
          $display("FAIL bad_sel3: got err=%b sel=%0d y=%h want err=1 sel=1 y=5", err0, cs0, y0);
        end
      end
    end
    load0 = 1'b0;
  endtask

  task automatic test_back_to_back();
    e0_t e;
    logic [1:0] seq [4];
    seq = '{2'd0, 2'd1, 2'd2, 2'd1};
    scan0 = 1'b0;
    for (int r = 0; r < 44; r++) begin
      if (r < 4) begin
        load0 = 1'b1;
        sel0  = seq[r];
      end else begin
        if ($urandom_range(0, 5) == 0) scan0 = ~scan0;
        load0 = 1'($urandom_range(0, 1));
        sel0  = 2'($urandom_range(0, 3));
        i0    = 12'($urandom);
      end
      step0();
      e = q0.pop_front();
      total++;
      if ({y0, cs0, vld0, err0} !== e) begin
        bad++;
        $display("FAIL b2b[%0d]: got y=%h sel=%0d vld=%b err=%b want y=%h sel=%0d vld=%b err=%b",
                 r, y0, cs0, vld0, err0, e.y, e.cs, e.vld, e.err);
      end
    end
    load0 = 1'b0;
  endtask

  task automatic test_scan();
    e0_t e;
    int  np;
    int  code;
    np = 0;
    code = 0;
    for (int r = 0; r < 14; r++) begin
      scan0 = (r >= 2);
      load0 = (r == 1) ? 1'b1 : ((r >= 3) ? 1'($urandom_range(0, 1)) : 1'b0);
      sel0  = (r == 1) ? 2'd0 : 2'($urandom_range(0, 3));
      i0    = 12'($urandom);
      step0();
      e = q0.pop_front();
      total++;
      if ({y0, cs0, vld0, err0} !== e) begin
        bad++;
        $display("FAIL scan[%0d]: got y=%h sel=%0d vld=%b err=%b want y=%h sel=%0d vld=%b err=%b",
                 r, y0, cs0, vld0, err0, e.y, e.cs, e.vld, e.err);
      end
      if (r >= 2 && vld0 === 1'b1) begin
        np++;
        code = code * 4 + int'(cs0);
      end
    end
    total++;
    if (np != 3 || code != 24) begin
      bad++;
      $display("FAIL scan_seq: got pulses=%0d code=%0d want pulses=3 code=24", np, code);
    end
    load0 = 1'b0;
  endtask

  task automatic test_exit_tc();
    e0_t  e;
    logic [1:0] held;
    bit   hit;
    hit = 1'b0;
    load0 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (!hit) begin
        if (m_st && m_cnt == 2) begin
          hit = 1'b1;
        end else begin
          step0();
          e = q0.pop_front();
          total++;
          if ({y0, cs0, vld0, err0} !== e) begin
            bad++;
            $display("FAIL exit_run[%0d]: got y=%h sel=%0d vld=%b err=%b want y=%h sel=%0d vld=%b err=%b",
                     k, y0, cs0, vld0, err0, e.y, e.cs, e.vld, e.err);
          end
        end
      end
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL exit_reach: got hit=0 want hit=1");
    end
    held = cs0;
    for (int r = 0; r < 3; r++) begin
      scan0 = 1'b0;
      load0 = (r < 2);
      sel0  = (held == 2'd2) ? 2'd0 : 2'd2;
      step0();
      e = q0.pop_front();
      total++;
      if ({y0, cs0, vld0, err0} !== e) begin
        bad++;
        $display("FAIL exit_tc[%0d]: got y=%h sel=%0d vld=%b err=%b want y=%h sel=%0d vld=%b err=%b",
                 r, y0, cs0, vld0, err0, e.y, e.cs, e.vld, e.err);
      end
      if (r == 0) begin
        total++;
        if (cs0 !== held || vld0 !== 1'b0 || err0 !== 1'b0) begin
          bad++;
          $display("FAIL exit_hold: got sel=%0d vld=%b err=%b want sel=%0d vld=0 err=0", cs0, vld0, err0, held);
        end
      end
      if (r == 1) begin
        total++;
        if (cs0 !== sel0 || vld0 !== 1'b1) begin
          bad++;
          $display("FAIL exit_load: got sel=%0d vld=%b want sel=%0d vld=1", cs0, vld0, sel0);
        end
      end
    end
    load0 = 1'b0;
  endtask

`ifdef B_MUX_CH_MASK_EN
  task automatic test_mask();
    e0_t e;
    int  np;
    int  code;
    np = 0;
    code = 0;
    ch_mask0 = 3'b111;
    for (int r = 0; r < 20; r++) begin
      scan0 = (r >= 2 && r < 16);
      load0 = (r == 1) || (r == 17) || (r == 18);
      sel0  = (r == 1) ? 2'd0 : 2'd1;
      if (r == 2) ch_mask0 = 3'b101;
      if (r == 12) ch_mask0 = 3'b000;
      if (r == 17) ch_mask0 = 3'b101;
      step0();
      e = q0.pop_front();
      total++;
      if ({y0, cs0, vld0, err0} !== e) begin
        bad++;
        $display("FAIL mask[%0d]: got y=%h sel=%0d vld=%b err=%b want y=%h sel=%0d vld=%b err=%b",
                 r, y0, cs0, vld0, err0, e.y, e.cs, e.vld, e.err);
      end
      if (r >= 2 && r < 12 && vld0 === 1'b1) begin
        np++;
        code = code * 4 + int'(cs0);
      end
      if (r >= 12 && r < 16) begin
        total++;
        if (vld0 !== 1'b0) begin
          bad++;
          $display("FAIL mask_none[%0d]: got vld=%b want vld=0", r, vld0);
        end
      end
      if (r == 17) begin
        total++;
        if (err0 !== 1'b1 || vld0 !== 1'b0) begin
          bad++;
          $display("FAIL mask_load: got err=%b vld=%b want err=1 vld=0", err0, vld0);
        end
      end
    end
    total++;
    if (np != 3 || code != 34) begin
      bad++;
      $display("FAIL mask_seq: got pulses=%0d code=%0d want pulses=3 code=34", np, code);
    end
    ch_mask0 = 3'b111;
    load0 = 1'b0;
  endtask
`endif

  task automatic test_n1();
    logic [9:0] rows [9];
    e1_t e;
    rows[0] = {1'b1, 1'b0, 1'b0, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0};
    rows[1] = {1'b1, 1'b0, 1'b0, 2'b10, 2'b10, 1'b0, 1'b1, 1'b0};
    rows[2] = {1'b1, 1'b1, 1'b1, 2'b10, 2'b10, 1'b0, 1'b1, 1'b0};
    rows[3] = {1'b1, 1'b0, 1'b0, 2'b10, 2'b10, 1'b0, 1'b1, 1'b0};
    rows[4] = {1'b1, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 1'b1, 1'b0};
    rows[5] = {1'b0, 1'b1, 1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0};
    rows[6] = {1'b0, 1'b1, 1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 1'b1};
    rows[7] = {1'b0, 1'b1, 1'b0, 2'b01, 2'b01, 1'b0, 1'b1, 1'b0};
    rows[8] = {1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0};
    for (int r = 0; r < 9; r++) begin
      {scan1, load1, sel1, i1} = rows[r][9:5];
      step1(e1_t'(rows[r][4:0]));
      e = q1.pop_front();
      total++;
      if ({y1, cs1, vld1, err1} !== e) begin
        bad++;
        $display("FAIL n1[%0d]: got y=%h sel=%0d vld=%b err=%b want y=%h sel=%0d vld=%b err=%b",
                 r, y1, cs1, vld1, err1, e.y, e.cs, e.vld, e.err);
      end
    end
  endtask

  task automatic test_reset_mid();
    e0_t e;
    bit  hit;
    hit = 1'b0;
    i0 = 12'h321;
    load0 = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (!hit) begin
        scan0 = (k > 0);
        step0();
        e = q0.pop_front();
        total++;
        if ({y0, cs0, vld0, err0} !== e) begin
          bad++;
          $display("FAIL mid_run[%0d]: got y=%h sel=%0d vld=%b err=%b want y=%h sel=%0d vld=%b err=%b",
                   k, y0, cs0, vld0, err0, e.y, e.cs, e.vld, e.err);
        end
        if (m_st && m_sel == 1 && m_cnt == 1) hit = 1'b1;
      end
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL mid_reach: got hit=0 want hit=1");
    end
    rst_n = 1'b0;
    #2;
    total++;
    if ({y0, cs0, vld0, err0} !== 8'h00) begin
      bad++;
      $display("FAIL reset_mid: got %h want 00", {y0, cs0, vld0, err0});
    end
    @(posedge clk);
    #1;
    total++;
    if ({y0, cs0, vld0, err0} !== 8'h00) begin
      bad++;
      $display("FAIL reset_hold: got %h want 00", {y0, cs0, vld0, err0});
    end
    scan0 = 1'b0;
    rst_n = 1'b1;
    m_st  = 1'b0;
    m_cnt = 0;
    m_sel = 0;
    q0.delete();
    step0();
    e = q0.pop_front();
    total++;
    if ({y0, cs0, vld0, err0} !== e) begin
      bad++;
      $display("FAIL post_reset: got y=%h sel=%0d vld=%b err=%b want y=%h sel=%0d vld=%b err=%b",
               y0, cs0, vld0, err0, e.y, e.cs, e.vld, e.err);
    end
  endtask

  initial begin
    i0 = '0;
    scan0 = 1'b0;
    load0 = 1'b0;
    sel0 = '0;
    i1 = '0;
    scan1 = 1'b0;
    load1 = 1'b0;
    sel1 = '0;
`ifdef B_MUX_CH_MASK_EN
    ch_mask0 = 3'b111;
`endif
    m_st = 1'b0;
    m_cnt = 0;
    m_sel = 0;
    #3;
    test_reset();
    test_manual();
    test_bad_sel();
    test_back_to_back();
    test_scan();
    test_exit_tc();
`ifdef B_MUX_CH_MASK_EN
    test_mask();
`endif
    test_n1();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
